npu_sched_engine: RTL and testbench

NPU_SCHED_ENGINE -- requirements
Module: npu_sched_engine

---
 rtl/npu_sched_pkg.sv | 34 +++
 rtl/npu_sched_engine_if.sv | 39 +++
 rtl/npu_sched_store.sv | 20 ++
 rtl/npu_sched_engine.sv | 116 +++++++++++
 tb/tb_npu_sched_engine.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/npu_sched_pkg.sv
// npu_sched_pkg: shared state enum, program entry field layout and width helpers
package npu_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  localparam int OFF_INPUT_RD = 0;
  localparam int OFF_SIG_RD = 1;
  localparam int OFF_SIG_WR = 2;
  localparam int OFF_OUT_WR = 3;
  localparam int OFF_PE_SEL = 4;
  localparam int FUNC_W = 2;
  function automatic int sched_w(input int psw, input int rpt_w);
    return 10 + 2 * psw + rpt_w;
  endfunction
  function automatic int off_pe_wr(input int psw);
    return 4 + psw;
  endfunction
  function automatic int off_acc_rd(input int psw);
    return 5 + psw;
  endfunction
  function automatic int off_acc_wr(input int psw);
    return 6 + psw;
  endfunction
  function automatic int off_sig_sel(input int psw);
    return 7 + psw;
  endfunction
  function automatic int off_offset_rd(input int psw);
    return 7 + 2 * psw;
  endfunction
  function automatic int off_func(input int psw);
    return 8 + 2 * psw;
  endfunction
  function automatic int off_rpt(input int psw);
    return 10 + 2 * psw;
  endfunction
endpackage

// File: rtl/npu_sched_engine_if.sv
// npu_sched_engine_if: program load, run control and decoded control outputs of the scheduler
interface npu_sched_engine_if #(parameter int PSW = 3, parameter int SCHED_W = 20);
  logic npu_sched_write_en;
  logic [SCHED_W-1:0] npu_sched_din;
  logic npu_sched_start;
  logic npu_sched_stall;
  logic npu_sched_busy;
  logic npu_sched_done;
  logic npu_sched_err;
  logic npu_sched_input_fifo_read_en;
  logic npu_sched_sigmoid_fifo_read_en;
  logic npu_sched_sigmoid_fifo_write_en;
  logic npu_sched_output_fifo_write_en;
  logic npu_sched_pe_write_en;
  logic npu_sched_acc_fifo_read_en;
  logic npu_sched_acc_fifo_write_en;
  logic npu_sched_offset_bram_read_en;
  logic [PSW-1:0] npu_sched_pe_select_in;
  logic [PSW-1:0] npu_sched_sigmoid_input_sel_pe;
  logic [1:0] npu_sched_sigmoid_function_sel;
  modport master (
    output npu_sched_write_en, npu_sched_din, npu_sched_start, npu_sched_stall,
    input npu_sched_busy, npu_sched_done, npu_sched_err,
    input npu_sched_input_fifo_read_en, npu_sched_sigmoid_fifo_read_en,
    input npu_sched_sigmoid_fifo_write_en, npu_sched_output_fifo_write_en,
    input npu_sched_pe_write_en, npu_sched_acc_fifo_read_en, npu_sched_acc_fifo_write_en,
    input npu_sched_offset_bram_read_en, npu_sched_pe_select_in,
    input npu_sched_sigmoid_input_sel_pe, npu_sched_sigmoid_function_sel
  );
  modport slave (
    input npu_sched_write_en, npu_sched_din, npu_sched_start, npu_sched_stall,
    output npu_sched_busy, npu_sched_done, npu_sched_err,
    output npu_sched_input_fifo_read_en, npu_sched_sigmoid_fifo_read_en,
    output npu_sched_sigmoid_fifo_write_en, npu_sched_output_fifo_write_en,
    output npu_sched_pe_write_en, npu_sched_acc_fifo_read_en, npu_sched_acc_fifo_write_en,
    output npu_sched_offset_bram_read_en, npu_sched_pe_select_in,
    output npu_sched_sigmoid_input_sel_pe, npu_sched_sigmoid_function_sel
  );
endinterface

// File: rtl/npu_sched_store.sv
// npu_sched_store: program memory, sync write, async control read plus async repeat lookahead
module npu_sched_store #(
  parameter int DEPTH = 32,
  parameter int W = 20,
  parameter int RPT_W = 4
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [W-1:0]             i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [W-RPT_W-1:0]       o_rd_ctrl,
  input  logic [$clog2(DEPTH)-1:0] i_nxt_addr,
  output logic [RPT_W-1:0]         o_nxt_rpt
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  assign o_rd_ctrl = r_mem[i_rd_addr][W-RPT_W-1:0];
  assign o_nxt_rpt = r_mem[i_nxt_addr][W-1:W-RPT_W];
endmodule

// File: rtl/npu_sched_engine.sv
// npu_sched_engine: loads a control program and replays it entry by entry with repeats and stall
module npu_sched_engine
  import npu_sched_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int PE_COUNT = 8,
  parameter int RPT_W = 4
) (
  input logic CLK,
  input logic npu_rst,
  npu_sched_engine_if.slave bus
);
  localparam int PSW = $clog2(PE_COUNT);
  localparam int SCHED_W = sched_w(PSW, RPT_W);
  localparam int CW = SCHED_W - RPT_W;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int O_PE_WR = off_pe_wr(PSW);
  localparam int O_ACC_RD = off_acc_rd(PSW);
  localparam int O_ACC_WR = off_acc_wr(PSW);
  localparam int O_SIG_SEL = off_sig_sel(PSW);
  localparam int O_OFFSET_RD = off_offset_rd(PSW);
  localparam int O_FUNC = off_func(PSW);
  state_t r_state, w_state;
  logic [AW-1:0] r_wr_ptr, w_wr_ptr, r_rd_ptr, w_rd_ptr, w_nxt_addr;
  logic [LW-1:0] r_prog_len, w_prog_len;
  logic [RPT_W-1:0] r_rpt_cnt, w_rpt_cnt, w_nxt_rpt;
  logic r_err, w_err, w_we, w_last;
  logic [CW-1:0] w_ctrl, w_act;
  npu_sched_store #(.DEPTH(DEPTH), .W(SCHED_W), .RPT_W(RPT_W)) u_store (
    .clk(CLK),
    .i_we(w_we),
    .i_wr_addr(r_wr_ptr),
    .i_wr_data(bus.npu_sched_din),
    .i_rd_addr(r_rd_ptr),
    .o_rd_ctrl(w_ctrl),
    .i_nxt_addr(w_nxt_addr),
    .o_nxt_rpt(w_nxt_rpt)
  );
  // lookahead port fetches the repeat count of the entry about to be loaded
  assign w_nxt_addr = r_state == S_IDLE ? '0 : r_rd_ptr + AW'(1);
  assign w_last = ({1'b0, r_rd_ptr} == r_prog_len - LW'(1)) && (r_rpt_cnt == '0);
  always_comb begin
    w_state = r_state;
    w_wr_ptr = r_wr_ptr;
    w_rd_ptr = r_rd_ptr;
    w_prog_len = r_prog_len;
    w_rpt_cnt = r_rpt_cnt;
    w_err = 1'b0;
    w_we = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.npu_sched_write_en) begin
          if (r_prog_len == LW'(DEPTH)) w_err = 1'b1;
          else begin
            w_we = 1'b1;
            w_wr_ptr = r_wr_ptr + AW'(1);
            w_prog_len = r_prog_len + LW'(1);
          end
        end
        if (bus.npu_sched_start) begin
          w_state = r_prog_len == '0 ? S_DONE : S_RUN;
          w_rd_ptr = '0;
          w_rpt_cnt = w_nxt_rpt;
        end
      end
      S_RUN: begin
        w_err = bus.npu_sched_write_en;
        if (!bus.npu_sched_stall) begin
          if (r_rpt_cnt != '0) w_rpt_cnt = r_rpt_cnt - RPT_W'(1);
          else if (w_last) w_state = S_DONE;
          else begin
            w_rd_ptr = r_rd_ptr + AW'(1);
            w_rpt_cnt = w_nxt_rpt;
          end
        end
      end
      default: begin
        w_err = bus.npu_sched_write_en;
        w_state = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge CLK) begin
    if (npu_rst) begin
      r_state <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_prog_len <= '0;
      r_rpt_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state;
      r_wr_ptr <= w_wr_ptr;
      r_rd_ptr <= w_rd_ptr;
      r_prog_len <= w_prog_len;
      r_rpt_cnt <= w_rpt_cnt;
      r_err <= w_err;
    end
  end
  assign w_act = (r_state == S_RUN && !bus.npu_sched_stall) ? w_ctrl : '0;
  assign bus.npu_sched_busy = r_state != S_IDLE;
  assign bus.npu_sched_done = r_state == S_DONE;
  assign bus.npu_sched_err = r_err;
  assign bus.npu_sched_input_fifo_read_en = w_act[OFF_INPUT_RD];
  assign bus.npu_sched_sigmoid_fifo_read_en = w_act[OFF_SIG_RD];
  assign bus.npu_sched_sigmoid_fifo_write_en = w_act[OFF_SIG_WR];
  assign bus.npu_sched_output_fifo_write_en = w_act[OFF_OUT_WR];
  assign bus.npu_sched_pe_select_in = w_act[OFF_PE_SEL +: PSW];
  assign bus.npu_sched_pe_write_en = w_act[O_PE_WR];
  assign bus.npu_sched_acc_fifo_read_en = w_act[O_ACC_RD];
  assign bus.npu_sched_acc_fifo_write_en = w_act[O_ACC_WR];
  assign bus.npu_sched_sigmoid_input_sel_pe = w_act[O_SIG_SEL +: PSW];
  assign bus.npu_sched_offset_bram_read_en = w_act[O_OFFSET_RD];
  assign bus.npu_sched_sigmoid_function_sel = w_act[O_FUNC +: FUNC_W];
endmodule

// File: tb/tb_npu_sched_engine.sv
// tb_npu_sched_engine: directed vector table plus hand sequences for reset, empty and overflow cases
module tb_npu_sched_engine;
  import npu_sched_pkg::*;
  localparam int DEPTH = 32;
  localparam int PE = 4;
  localparam int PSW = 2;
  localparam int RPT = 4;
  localparam int SW = sched_w(PSW, RPT);
  localparam int CW = SW - RPT;
  typedef struct {
    logic wr;
    logic [SW-1:0] din;
    logic start;
    logic stall;
    logic busy;
    logic done;
    logic err;
    logic [CW-1:0] ctrl;
  } vec_t;
  logic clk, rst;
  int tests, fails;
  vec_t vt[$];
  npu_sched_engine_if #(.PSW(PSW), .SCHED_W(SW)) bus ();
  npu_sched_engine #(.DEPTH(DEPTH), .PE_COUNT(PE), .RPT_W(RPT)) dut (
    .CLK(clk),
    .npu_rst(rst),
    .bus(bus)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  function automatic logic [SW-1:0] mk(input logic [CW-1:0] c, input logic [RPT-1:0] r);
    return {r, c};
  endfunction
  function automatic logic [CW-1:0] obs();
    return {bus.npu_sched_sigmoid_function_sel, bus.npu_sched_offset_bram_read_en,
            bus.npu_sched_sigmoid_input_sel_pe, bus.npu_sched_acc_fifo_write_en,
            bus.npu_sched_acc_fifo_read_en, bus.npu_sched_pe_write_en,
            bus.npu_sched_pe_select_in, bus.npu_sched_output_fifo_write_en,
            bus.npu_sched_sigmoid_fifo_write_en, bus.npu_sched_sigmoid_fifo_read_en,
            bus.npu_sched_input_fifo_read_en};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic apply(input logic r, input logic w, input logic [SW-1:0] d, input logic s, input logic st);
    rst = r;
    bus.npu_sched_write_en = w;
    bus.npu_sched_din = d;
    bus.npu_sched_start = s;
    bus.npu_sched_stall = st;
    #2;
  endtask
  task automatic chk(input string name, input logic b, input logic d, input logic e, input logic [CW-1:0] c);
    tests++;
    if (bus.npu_sched_busy !== b || bus.npu_sched_done !== d || bus.npu_sched_err !== e || obs() !== c) begin
      fails++;
      $display("FAIL %s: got busy=%b done=%b err=%b ctrl=%h, expected busy=%b done=%b err=%b ctrl=%h",
               name, bus.npu_sched_busy, bus.npu_sched_done, bus.npu_sched_err, obs(), b, d, e, c);
    end
  endtask
  task automatic add(input logic w, input logic [SW-1:0] d, input logic s, input logic st,
                     input logic b, input logic dn, input logic e, input logic [CW-1:0] c);
    vt.push_back('{w, d, s, st, b, dn, e, c});
  endtask
  localparam logic [CW-1:0] C0 = 14'h2431;
  localparam logic [CW-1:0] C1 = 14'h0246;
  localparam logic [CW-1:0] C2 = 14'h1988;
  initial begin
    tests = 0;
    fails = 0;
    apply(1'b1, 1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("reset", 1'b0, 1'b0, 1'b0, '0);
    tick();
    add(1, mk(C0, 0), 0, 0, 0, 0, 0, '0);
    add(1, mk(C1, 2), 0, 0, 0, 0, 0, '0);
    add(1, mk(C2, 1), 0, 0, 0, 0, 0, '0);
    add(0, '0, 1, 0, 0, 0, 0, '0);
    add(0, '0, 0, 0, 1, 0, 0, C0);
    add(0, '0, 0, 0, 1, 0, 0, C1);
    add(0, '0, 0, 0, 1, 0, 0, C1);
    add(0, '0, 0, 0, 1, 0, 0, C1);
    add(0, '0, 0, 0, 1, 0, 0, C2);
    add(0, '0, 0, 0, 1, 0, 0, C2);
    add(0, '0, 0, 0, 1, 1, 0, '0);
    add(0, '0, 0, 0, 0, 0, 0, '0);
    add(0, '0, 1, 0, 0, 0, 0, '0);
    add(0, '0, 0, 0, 1, 0, 0, C0);
    add(0, '0, 1, 0, 1, 0, 0, C1);
    add(1, mk(14'h3fff, 3), 0, 0, 1, 0, 0, C1);
    add(0, '0, 0, 0, 1, 0, 1, C1);
    add(0, '0, 0, 0, 1, 0, 0, C2);
    add(0, '0, 0, 0, 1, 0, 0, C2);
    add(0, '0, 0, 0, 1, 1, 0, '0);
    add(0, '0, 0, 0, 0, 0, 0, '0);
    add(0, '0, 1, 0, 0, 0, 0, '0);
    add(0, '0, 0, 0, 1, 0, 0, C0);
    add(0, '0, 0, 0, 1, 0, 0, C1);
    add(0, '0, 0, 1, 1, 0, 0, '0);
    add(0, '0, 0, 1, 1, 0, 0, '0);
    add(0, '0, 0, 0, 1, 0, 0, C1);
    add(0, '0, 0, 0, 1, 0, 0, C1);
    add(0, '0, 0, 0, 1, 0, 0, C2);
    add(0, '0, 0, 0, 1, 0, 0, C2);
    add(0, '0, 0, 0, 1, 1, 0, '0);
    add(0, '0, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < vt.size(); i++) begin
      apply(1'b0, vt[i].wr, vt[i].din, vt[i].start, vt[i].stall);
      chk($sformatf("vec[%0d]", i), vt[i].busy, vt[i].done, vt[i].err, vt[i].ctrl);
      tick();
    end
    apply(1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick();
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("rst_run_c1", 1'b1, 1'b0, 1'b0, C0);
    tick();
    apply(1'b1, 1'b1, mk(C0, 0), 1'b0, 1'b0);
    chk("rst_run_c2", 1'b1, 1'b0, 1'b0, C1);
    tick();
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("rst_after", 1'b0, 1'b0, 1'b0, '0);
    tick();
    apply(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("empty_start", 1'b0, 1'b0, 1'b0, '0);
    tick();
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("empty_done", 1'b1, 1'b1, 1'b0, '0);
    tick();
    chk("empty_idle", 1'b0, 1'b0, 1'b0, '0);
    tick();
    for (int i = 0; i < 33; i++) begin
      apply(1'b0, 1'b1, i < 32 ? mk(CW'(i * 37 + 1), 0) : mk(14'h3fff, 0), 1'b0, 1'b0);
      chk($sformatf("ovf_wr[%0d]", i), 1'b0, 1'b0, 1'b0, '0);
      tick();
    end
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("ovf_err", 1'b0, 1'b0, 1'b1, '0);
    tick();
    apply(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("ovf_err_clr", 1'b0, 1'b0, 1'b0, '0);
    tick();
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("ovf_run[%0d]", i), 1'b1, 1'b0, 1'b0, CW'(i * 37 + 1));
      tick();
    end
    chk("ovf_done", 1'b1, 1'b1, 1'b0, '0);
    tick();
    chk("ovf_idle", 1'b0, 1'b0, 1'b0, '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
